// File: rtl/clk_activity_led_gen.sv
// clk_activity_led_gen: prescale counter on the observed clock shown on LEDs as binary, Gray, heartbeat or bounce-sweep.
// Optional PWM dimming through the brightness port when LED_PWM_DIM_EN is defined.
module clk_activity_led_gen #(
    parameter int CNT_WIDTH      = 30,
    parameter int NUM_LEDS       = 4,
    parameter int SWEEP_DIV_LOG2 = 22,
    parameter bit LED_ACTIVE_LOW = 1'b1,
    parameter int PWM_WIDTH      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           mode,
`ifdef LED_PWM_DIM_EN
    input  logic [PWM_WIDTH-1:0] brightness,
`endif
    output logic [CNT_WIDTH-1:0] count_out,
    output logic                 tick,
    output logic [NUM_LEDS-1:0]  led
);
    localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [PW-1:0] POS_MAX = PW'(NUM_LEDS - 1);
    localparam logic [NUM_LEDS-1:0] UNLIT = {NUM_LEDS{LED_ACTIVE_LOW}};

    typedef enum logic {UP, DOWN} dir_e;

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 tick_q, tick_d;
    logic [1:0]           mode_q;
    logic [PW-1:0]        pos_q, pos_d;
    dir_e                 dir_q, dir_d;
    logic [NUM_LEDS-1:0]  led_q, led_d, top, pat, lit;
    logic [2:0]           h;
    logic                 led_upd;

`ifdef LED_PWM_DIM_EN
    logic [PWM_WIDTH-1:0] pwm_q;
    always_ff @(posedge clk) begin
        if (reset) pwm_q <= '0;
        else       pwm_q <= pwm_q + 1'b1;
    end
    assign lit     = (pwm_q < brightness) ? pat : '0;
    // dimming needs a fresh drive value every clock, so the LED register cannot hold on enable=0
    assign led_upd = 1'b1;
`else
    logic unused_pwm;
    assign unused_pwm = PWM_WIDTH[0];
    assign lit        = pat;
    assign led_upd    = enable;
`endif

    assign top = count_q[CNT_WIDTH-1 -: NUM_LEDS];
    assign h   = count_q[CNT_WIDTH-1 -: 3];

    always_comb begin
        count_d = enable ? count_q + 1'b1 : count_q;
        tick_d  = enable && (&count_q[SWEEP_DIV_LOG2-1:0]);
        pos_d   = pos_q;
        dir_d   = dir_q;
        pat     = mode_q == 2'd0 ? top :
                  mode_q == 2'd1 ? top ^ (top >> 1) :
                  mode_q == 2'd2 ? {NUM_LEDS{~h[2] & ~h[0]}} :
                                   NUM_LEDS'(1) << pos_q;
        led_d   = led_upd ? lit ^ UNLIT : led_q;
        if (mode != mode_q) begin
            pos_d = '0;
            dir_d = UP;
        end else if (tick_q && enable && NUM_LEDS > 1) begin
            if (dir_q == UP) begin
                pos_d = (pos_q == POS_MAX) ? pos_q - 1'b1 : pos_q + 1'b1;
                dir_d = (pos_q == POS_MAX) ? DOWN : UP;
            end else begin
                pos_d = (pos_q == '0) ? pos_q + 1'b1 : pos_q - 1'b1;
                dir_d = (pos_q == '0) ? UP : DOWN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
            mode_q  <= 2'd0;
            pos_q   <= '0;
            dir_q   <= UP;
            led_q   <= UNLIT;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
            mode_q  <= mode;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            led_q   <= led_d;
        end
    end

    assign count_out = count_q;
    assign tick      = tick_q;
    assign led       = led_q;
endmodule
